// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing one segment bus.
// Front bank is written by the host; the display bank is refreshed only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic [7:0] digit_en,
  input  logic       lz_blank,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int unsigned CntW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
  localparam logic [2:0]      IdxMax = 3'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {StGap, StShow} state_e;

  // With no blank gap the FSM must never sit in StGap, not even straight out of reset.
  localparam state_e StRst = (BLANK_CYC == 0) ? StShow : StGap;

  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  state_e                          state_q, state_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [2:0]                      idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]      front_val_q, front_val_d;
  logic [NUM_DIGITS-1:0]           front_dp_q, front_dp_d;
  logic [NUM_DIGITS-1:0][3:0]      disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]           disp_dp_q, disp_dp_d;
  logic [7:0]                      an_q, an_d;
  logic [6:0]                      seg_q, seg_d;
  logic                            dp_q, dp_d;
  logic                            frame_done_q, frame_done_d;

  logic                  slot_end;
  logic                  frame_end;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  above_zero;
  logic [3:0]            cur_val;
  logic                  cur_dp;
  logic                  cur_lz;
  logic                  cur_en;

  // Slot counter, digit index and FSM
  always_comb begin
    slot_end  = (cnt_q == CntMax);
    frame_end = slot_end && (idx_q == IdxMax);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxMax) ? 3'd0 : idx_q + 3'd1;
    end
    state_d = (32'(cnt_d) < BLANK_CYC) ? StGap : StShow;
  end

  // Front bank write and frame-boundary copy; the copy sees this cycle's write.
  always_comb begin
    front_val_d = front_val_q;
    front_dp_d  = front_dp_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (wr_en && (wr_addr == 3'(i))) begin
        front_val_d[i] = wr_data;
        front_dp_d[i]  = wr_dp;
      end
    end
    disp_val_d = frame_end ? front_val_d : disp_val_q;
    disp_dp_d  = frame_end ? front_dp_d  : disp_dp_q;
  end

  // Leading-zero mask: walk from the most significant digit down.
  always_comb begin
    lz_mask    = '0;
    above_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_mask[i] = (i != 0) && above_zero && (disp_val_q[i] == 4'h0);
      above_zero = above_zero && (disp_val_q[i] == 4'h0);
    end
  end

  always_comb begin
    cur_val = 4'h0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    cur_en  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        cur_val = disp_val_q[i];
        cur_dp  = disp_dp_q[i];
        cur_lz  = lz_mask[i];
        cur_en  = digit_en[i];
      end
    end
  end

  always_comb begin
    an_d         = 8'hFF;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    frame_done_d = frame_end;
    if ((state_q == StShow) && cur_en && !(lz_blank && cur_lz)) begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = hex2seg(cur_val);
      dp_d  = ~cur_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRst;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      front_val_q  <= '0;
      front_dp_q   <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      front_val_q  <= front_val_d;
      front_dp_q   <= front_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a 4-digit and a 1-digit instance, expectations queued per cycle
// by the stimulus and checked by an independent monitor on the falling clock edge.
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] digit_en;
  logic       lz_blank;

  logic       wr_en0, wr_dp0, wr_en1, wr_dp1;
  logic [2:0] wr_addr0, wr_addr1;
  logic [3:0] wr_data0, wr_data1;
  logic [7:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1, fd0, fd1;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .wr_dp(wr_dp0), .digit_en(digit_en), .lz_blank(lz_blank), .an(an0), .seg(seg0),
    .dp(dp0), .frame_done(fd0)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(1), .REFRESH_DIV(4), .BLANK_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .wr_dp(wr_dp1), .digit_en(digit_en), .lz_blank(lz_blank), .an(an1), .seg(seg1),
    .dp(dp1), .frame_done(fd1)
  );

  localparam logic [6:0] Dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    int         cyc;
    bit         sel;
    string      name;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input int c, input bit sel, input string name, input logic [7:0] a,
                      input logic [6:0] s, input logic d, input logic f);
    exp_t it;
    it.cyc = c; it.sel = sel; it.name = name; it.an = a; it.seg = s; it.dp = d; it.fd = f;
    q.push_back(it);
  endtask

  // One 4-digit frame as seen on the pins after frame_done at cycle c.
  task automatic push_frame(input int c, input string name, input logic [27:0] segs,
                            input logic [3:0] dpo, input logic [3:0] lit);
    for (int k = 1; k <= 16; k++) begin
      int d;
      int ph;
      d  = (k - 1) / 4;
      ph = (k - 1) % 4;
      if (ph == 0 || !lit[d]) push(c + k, 1'b0, name, 8'hFF, 7'h7F, 1'b1, k == 16);
      else push(c + k, 1'b0, name, ~(8'd1 << d), segs[d*7 +: 7], dpo[d], k == 16);
    end
  endtask

  task automatic check(input exp_t it);
    logic [7:0] a;
    logic [6:0] s;
    logic       d;
    logic       f;
    a = it.sel ? an1 : an0;
    s = it.sel ? seg1 : seg0;
    d = it.sel ? dp1 : dp0;
    f = it.sel ? fd1 : fd0;
    n_cmp++;
    if (it.cyc != cyc || a !== it.an || s !== it.seg || d !== it.dp || f !== it.fd) begin
      n_err++;
      $display("FAIL %s dut%0d cyc %0d (at %0d): got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=%b fd=%b",
               it.name, it.sel, it.cyc, cyc, a, s, d, f, it.an, it.seg, it.dp, it.fd);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < q.size(); ) begin
        if (q[i].cyc <= cyc) begin
          check(q[i]);
          q.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wr(input int n, input bit sel, input logic [2:0] a, input logic [3:0] d,
                    input logic p);
    step_to(n);
    if (sel) begin
      wr_en1 = 1'b1; wr_addr1 = a; wr_data1 = d; wr_dp1 = p;
    end else begin
      wr_en0 = 1'b1; wr_addr0 = a; wr_data0 = d; wr_dp0 = p;
    end
    step_to(n + 1);
    wr_en0 = 1'b0;
    wr_en1 = 1'b0;
  endtask

  task automatic wait_fd(input bit sel, output int c);
    c = cyc;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if ((sel ? fd1 : fd0) === 1'b1) begin
        c = cyc;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL frame_done_timeout dut%0d: got no pulse in 100 cycles, want a pulse", sel);
  endtask

  initial begin
    int c;
    int r;
    rst_n    = 1'b0;
    digit_en = 8'hFF;
    lz_blank = 1'b0;
    wr_en0 = 1'b0; wr_addr0 = 3'd0; wr_data0 = 4'h0; wr_dp0 = 1'b0;
    wr_en1 = 1'b0; wr_addr1 = 3'd0; wr_data1 = 4'h0; wr_dp1 = 1'b0;

    for (int k = 2; k <= 3; k++) begin
      push(k, 1'b0, "reset4", 8'hFF, 7'h7F, 1'b1, 1'b0);
      push(k, 1'b1, "reset1", 8'hFF, 7'h7F, 1'b1, 1'b0);
    end
    step_to(4);
    rst_n = 1'b1;
    wr(5, 1'b0, 3'd0, 4'h1, 1'b0);
    wr(7, 1'b0, 3'd1, 4'h2, 1'b0);
    wr(9, 1'b0, 3'd2, 4'h3, 1'b0);
    wr(11, 1'b0, 3'd3, 4'h4, 1'b0);

    // First frame with 1,2,3,4; mid-frame write is deferred, boundary write is not.
    wait_fd(1'b0, c);
    push_frame(c, "scan", {7'h19, 7'h30, 7'h24, 7'h79}, 4'hF, 4'hF);
    wr(c + 5, 1'b0, 3'd2, 4'hA, 1'b0);
    wr(c + 15, 1'b0, 3'd1, 4'h7, 1'b0);
    c += 16;
    push_frame(c, "coherent", {7'h19, 7'h08, 7'h78, 7'h79}, 4'hF, 4'hF);
    wr(c + 2, 1'b0, 3'd3, 4'h0, 1'b0);
    wr(c + 4, 1'b0, 3'd2, 4'h0, 1'b0);
    wr(c + 6, 1'b0, 3'd1, 4'h5, 1'b0);
    wr(c + 8, 1'b0, 3'd0, 4'h0, 1'b0);
    step_to(c + 16);
    lz_blank = 1'b1;
    c += 16;
    push_frame(c, "lz_0050", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF, 4'b0011);
    wr(c + 2, 1'b0, 3'd1, 4'h0, 1'b0);
    wr(c + 4, 1'b0, 3'd2, 4'h0, 1'b1);
    step_to(c + 16);
    c += 16;
    push_frame(c, "lz_all0", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 4'b0001);
    wr(c + 2, 1'b0, 3'd1, 4'h5, 1'b1);
    wr(c + 4, 1'b0, 3'd3, 4'hC, 1'b0);
    wr(c + 6, 1'b0, 3'd5, 4'h9, 1'b0);
    step_to(c + 16);
    lz_blank = 1'b0;
    digit_en = 8'h0A;
    c += 16;
    push_frame(c, "en_dp", {7'h46, 7'h7F, 7'h12, 7'h7F}, 4'b1101, 4'b1010);
    step_to(c + 16);
    digit_en = 8'hFF;
    c += 16;

    // Reset asserted two time units after a rising edge, sampled before the next one.
    push(c + 2, 1'b0, "pre_rst", 8'hFE, 7'h40, 1'b1, 1'b0);
    push(c + 3, 1'b0, "pre_rst", 8'hFE, 7'h40, 1'b1, 1'b0);
    for (int k = 4; k <= 6; k++) push(c + k, 1'b0, "async_rst", 8'hFF, 7'h7F, 1'b1, 1'b0);
    step_to(c + 3);
    #6;
    rst_n = 1'b0;
    step_to(c + 6);
    rst_n = 1'b1;
    r = c + 6;
    push(r + 1, 1'b0, "restart_gap", 8'hFF, 7'h7F, 1'b1, 1'b0);
    push(r + 2, 1'b0, "restart_d0", 8'hFE, 7'h40, 1'b1, 1'b0);
    push(r + 4, 1'b0, "restart_d0", 8'hFE, 7'h40, 1'b1, 1'b0);
    push(r + 5, 1'b0, "restart_gap1", 8'hFF, 7'h7F, 1'b1, 1'b0);
    push(r + 6, 1'b0, "cleared_d1", 8'hFD, 7'h40, 1'b1, 1'b0);
    push(r + 15, 1'b0, "cleared_d3", 8'hF7, 7'h40, 1'b1, 1'b0);
    push(r + 16, 1'b0, "restart_fd", 8'hF7, 7'h40, 1'b1, 1'b1);
    step_to(r + 16);

    // Decode sweep on the single-digit instance.
    wait_fd(1'b1, c);
    for (int v = 0; v < 16; v++) begin
      string nm;
      nm = $sformatf("decode_%h", v);
      push(c + 6, 1'b1, nm, 8'hFE, Dec[v], 1'b1, 1'b0);
      push(c + 7, 1'b1, nm, 8'hFE, Dec[v], 1'b1, 1'b0);
      push(c + 8, 1'b1, nm, 8'hFE, Dec[v], 1'b1, 1'b1);
      wr(c, 1'b1, 3'd0, 4'(v), 1'b0);
      wait_fd(1'b1, c);
    end
    step_to(c + 8);

    step_to(cyc + 3);
    while (q.size() > 0) begin
      exp_t it;
      it = q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL %s dut%0d cyc %0d: got never sampled, want a sample", it.name, it.sel,
               it.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
